// File: rtl/knn_host_master.sv
// Host-side sequencer for a KNN classifier peripheral: programs the test point, streams the
// training points over a native valid/ready bus, then reads back the winning label.
module knn_host_master #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned A_CONTROL    = 0,
  parameter int unsigned A_NK         = 1,
  parameter int unsigned A_XX         = 2,
  parameter int unsigned A_YY         = 3,
  parameter int unsigned A_DATA_X     = 4,
  parameter int unsigned A_DATA_Y     = 5,
  parameter int unsigned A_DATA_LABEL = 6,
  parameter int unsigned A_XLABEL     = 7,
  parameter logic [2:0]  CMD_INSERT   = 3'b001,
  parameter logic [2:0]  CMD_IDLE     = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   nk,
  input  logic [DATA_W-1:0]   test_x,
  input  logic [DATA_W-1:0]   test_y,
  input  logic [15:0]         n_points,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [DATA_W-1:0]   pt_x,
  input  logic [DATA_W-1:0]   pt_y,
  input  logic [7:0]          pt_label,
  output logic                busy,
  output logic                done,
  output logic [7:0]          label_out,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  typedef enum logic [3:0] {
    StIdle, StRstOn, StRstOff, StWrNk, StWrX, StWrY, StWaitPt,
    StWrDx, StWrDy, StWrDl, StWrCmd, StWrClr, StRdLbl
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, np_q;
  logic [DATA_W-1:0]   nk_q, tx_q, ty_q, py_q;
  logic [7:0]          lbl_q, label_q;
  logic                m_valid_q, busy_q, done_q, pt_ready_q;
  logic [ADDR_W-1:0]   m_address_q, addr_d;
  logic [DATA_W-1:0]   m_wdata_q, wdata_d;
  logic [DATA_W/8-1:0] m_wstrb_q, strb_d;
  logic                valid_d, fire;
  logic                unused_rdata;

  assign unused_rdata = ^m_rdata[DATA_W-1:8];
  assign fire         = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:   if (start) begin
        state_d = StRstOn;
        cnt_d   = '0;
      end
      StRstOn:  if (fire) state_d = StRstOff;
      StRstOff: if (fire) state_d = StWrNk;
      StWrNk:   if (fire) state_d = StWrX;
      StWrX:    if (fire) state_d = StWrY;
      StWrY:    if (fire) state_d = (np_q != 16'd0) ? StWaitPt : StRdLbl;
      StWaitPt: if (pt_valid) state_d = StWrDx;
      StWrDx:   if (fire) state_d = StWrDy;
      StWrDy:   if (fire) state_d = StWrDl;
      StWrDl:   if (fire) state_d = StWrCmd;
      StWrCmd:  if (fire) state_d = StWrClr;
      StWrClr:  if (fire) begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d == np_q) ? StRdLbl : StWaitPt;
      end
      StRdLbl:  if (fire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bus request for the state being entered; only loaded on a state change so it stays stable.
  always_comb begin
    valid_d = 1'b1;
    strb_d  = '1;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      StRstOn:  begin addr_d = ADDR_W'(A_CONTROL);    wdata_d = DATA_W'(1);                end
      StRstOff: begin addr_d = ADDR_W'(A_CONTROL);    wdata_d = '0;                        end
      StWrNk:   begin addr_d = ADDR_W'(A_NK);         wdata_d = nk_q;                      end
      StWrX:    begin addr_d = ADDR_W'(A_XX);         wdata_d = tx_q;                      end
      StWrY:    begin addr_d = ADDR_W'(A_YY);         wdata_d = ty_q;                      end
      StWrDx:   begin addr_d = ADDR_W'(A_DATA_X);     wdata_d = pt_x;                      end
      StWrDy:   begin addr_d = ADDR_W'(A_DATA_Y);     wdata_d = py_q;                      end
      StWrDl:   begin addr_d = ADDR_W'(A_DATA_LABEL); wdata_d = DATA_W'(lbl_q);            end
      StWrCmd:  begin addr_d = ADDR_W'(A_CONTROL);    wdata_d = DATA_W'({CMD_INSERT, 1'b0}); end
      StWrClr:  begin addr_d = ADDR_W'(A_CONTROL);    wdata_d = DATA_W'({CMD_IDLE, 1'b0});   end
      StRdLbl:  begin addr_d = ADDR_W'(A_XLABEL);     strb_d  = '0;                        end
      default:  begin valid_d = 1'b0;                 strb_d  = '0;                        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      np_q        <= '0;
      nk_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      py_q        <= '0;
      lbl_q       <= '0;
      label_q     <= '0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pt_ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && start) begin
        nk_q <= nk;
        tx_q <= test_x;
        ty_q <= test_y;
        np_q <= n_points;
      end
      if (state_q == StWaitPt && pt_valid) begin
        py_q  <= pt_y;
        lbl_q <= pt_label;
      end
      if (state_d != state_q) begin
        m_valid_q   <= valid_d;
        m_address_q <= addr_d;
        m_wdata_q   <= wdata_d;
        m_wstrb_q   <= strb_d;
      end
      busy_q     <= (state_d != StIdle);
      pt_ready_q <= (state_d == StWaitPt);
      done_q     <= (state_q == StRdLbl) && fire;
      if (state_q == StRdLbl && fire) label_q <= m_rdata[7:0];
    end
  end

  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pt_ready  = pt_ready_q;
  assign label_out = label_q;

endmodule

// File: doc/knn_host_master.md
KNN_HOST_MASTER -- requirements
Module: knn_host_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 5, bus address width; DATA_W, default 32, bus data width.
REQ-002 Register-address parameters SHALL be: A_CONTROL 0; A_NK 1; A_XX 2; A_YY 3; A_DATA_X 4; A_DATA_Y 5; A_DATA_LABEL 6; A_XLABEL 7.
REQ-003 Command-code parameters SHALL be: CMD_INSERT, default 3'b001, insert-point command; CMD_IDLE, default 3'b000, no-op command.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run one classification; ignored while busy=1.
REQ-007 nk  in  DATA_W  neighbour count; sampled at start.
REQ-008 test_x, test_y  in  DATA_W each  test-point coordinates; sampled at start.
REQ-009 n_points  in  16  number of training points to stream; sampled at start.
REQ-010 pt_valid, pt_ready  in/out  1 each  training-point handshake.
REQ-011 pt_x, pt_y  in  DATA_W each  training-point coordinates.
REQ-012 pt_label  in  8  training-point label.
REQ-013 busy, done  out  1 each  run in progress; one-cycle completion pulse.
REQ-014 label_out  out  8  classification result.
REQ-015 Native-bus master ports SHALL be: m_valid out 1; m_address out ADDR_W; m_wdata out DATA_W; m_wstrb out DATA_W/8; m_rdata in DATA_W; m_ready in 1.

Function
REQ-016 A bus transaction SHALL complete in the cycle m_valid=1 and m_ready=1; m_address, m_wdata and m_wstrb SHALL be held stable until that cycle.
REQ-017 Writes SHALL use m_wstrb all-ones; reads SHALL use m_wstrb=0 and m_wdata=0.
REQ-018 The FSM SHALL have states IDLE, RST_ON, RST_OFF, WR_NK, WR_X, WR_Y, WAIT_PT, WR_DX, WR_DY, WR_DL, WR_CMD, WR_CLR, RD_LBL.
REQ-019 In IDLE, start=1 SHALL latch nk, test_x, test_y and n_points, clear the point counter, and enter RST_ON.
REQ-020 Write states SHALL issue one write each and advance on completion: RST_ON, CONTROL=1; RST_OFF, CONTROL=0; WR_NK, nk; WR_X, test_x; WR_Y, test_y.
REQ-021 After WR_Y the FSM SHALL enter WAIT_PT if latched n_points>0, else RD_LBL.
REQ-022 pt_ready SHALL equal 1 only in WAIT_PT; m_valid SHALL be 0 in WAIT_PT and IDLE.
REQ-023 In WAIT_PT, pt_valid=1 SHALL capture pt_x, pt_y and pt_label and enter WR_DX; pt_valid=0 SHALL hold the state indefinitely.
REQ-024 Point writes SHALL be: WR_DX, pt_x; WR_DY, pt_y; WR_DL, zero-extended label; WR_CMD, CONTROL={CMD_INSERT,1'b0}; WR_CLR, CONTROL={CMD_IDLE,1'b0}.
REQ-025 On WR_CLR completion the counter SHALL increment and the FSM SHALL enter RD_LBL if the new count equals n_points, else WAIT_PT.
REQ-026 In RD_LBL, read A_XLABEL; on completion capture m_rdata[7:0] into label_out, pulse done for that next cycle, return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 The next transaction SHALL be presented in the cycle after the previous one completes, giving a minimum of 1 cycle per transaction.
REQ-029 label_out SHALL hold its value until the next RD_LBL completion.
REQ-030 A start pulse while busy SHALL have no effect; no outputs change.
REQ-031 n_points=65535 SHALL be supported without counter overflow.
REQ-032 m_ready asserted while m_valid=0 SHALL be ignored.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE and clear to 0 m_valid, m_address, m_wdata, m_wstrb, pt_ready, busy, done, label_out and the counter.
REQ-034 rst mid-transaction SHALL abandon the transaction, with m_valid 0 from the next cycle; no resumption.

Verification
REQ-035 Bench: n_points=2, responder m_ready=1 every valid cycle -> exactly 16 transactions in order CTRL 1, CTRL 0, NK, XX, YY, (DX, DY, DL, CTRL 2, CTRL 0) x2, read XLABEL; done pulses once.
REQ-036 Bench: n_points=0, XLABEL reads 0x0000_00A5 -> 5 writes then 1 read; label_out=0xA5; done pulses once; pt_ready never 1.
REQ-037 Bench: responder inserts 3 wait cycles per transaction -> m_address, m_wdata and m_wstrb stay stable while waiting; sequence identical to REQ-035.
REQ-038 Bench: pt_valid withheld 10 cycles in WAIT_PT -> pt_ready=1 and m_valid=0 throughout; resumes with WR_DX.
REQ-039 Bench: start re-pulsed during WR_DY -> no effect on sequence or latched parameters.
REQ-040 Bench: rst asserted in WR_CMD -> next cycle busy=0, m_valid=0, label_out=0; a new start then runs the full sequence.
